// File: rtl/dc_block_pkg.sv
// Shared defaults, sample type and saturation helper for the DC-blocking filter.
// Pure declarations: no logic, no latency, no flow control.
package dc_block_pkg;

  localparam int DC_DATA_W = 9;
  localparam int DC_SHIFT  = 10;

  typedef logic signed [DC_DATA_W-1:0] sample_t;

  // Overflow is visible as disagreement between the two top bits.
  function automatic sample_t sat(input logic signed [DC_DATA_W:0] x);
    sample_t r;
    r = x[DC_DATA_W-1:0];
    if (x[DC_DATA_W] != x[DC_DATA_W-1])
      r = x[DC_DATA_W] ? {1'b1, {(DC_DATA_W-1){1'b0}}} : {1'b0, {(DC_DATA_W-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/dc_block_iir_if.sv
// Sample-strobe bus of the DC-blocking filter; strobe qualified, no back-pressure.
// Optional bypass signal present when DC_FILTER_BYPASS_EN is defined.
interface dc_block_iir_if
  import dc_block_pkg::*;
#(
  parameter int DATA_W = DC_DATA_W
);
  logic                     enable_3M;
  logic signed [DATA_W-1:0] c_data;
  logic signed [DATA_W-1:0] o_data;
`ifdef DC_FILTER_BYPASS_EN
  logic                     bypass;
`endif

  modport master (
    output enable_3M,
    output c_data,
`ifdef DC_FILTER_BYPASS_EN
    output bypass,
`endif
    input  o_data
  );

  modport slave (
    input  enable_3M,
    input  c_data,
`ifdef DC_FILTER_BYPASS_EN
    input  bypass,
`endif
    output o_data
  );

endinterface

// File: rtl/dc_block_sat.sv
// Combinational clamp of a W+1-bit signed value into W bits; zero latency, no flow control.
module dc_block_sat
  import dc_block_pkg::*;
#(
  parameter int W = DC_DATA_W
) (
  input  logic signed [W:0]   value,
  output logic signed [W-1:0] clamped
);

  always_comb begin
    clamped = value[W-1:0];
    if (value[W] != value[W-1])
      clamped = value[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/dc_block_iir.sv
// Leaky-integrator DC removal; output registered one clock after the enable_3M strobe, no back-pressure.
// Optional DC_FILTER_BYPASS_EN adds a bypass that passes samples through and pre-loads the estimate.
module dc_block_iir
  import dc_block_pkg::*;
#(
  parameter int DATA_W = DC_DATA_W,
  parameter int SHIFT  = DC_SHIFT,
  parameter int ACC_W  = DATA_W + SHIFT + 1
) (
  input  logic           CLK_24M,
  input  logic           reset,
  dc_block_iir_if.slave  bus
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W:0]   est;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W-1:0] sat_out;

  // acc stays within +/-2^(DATA_W-1+SHIFT), so the floored estimate fits DATA_W+1 bits.
  assign est  = (DATA_W+1)'(acc >>> SHIFT);
  assign diff = (DATA_W+1)'(bus.c_data) - est;

  dc_block_sat #(.W(DATA_W)) u_sat (
    .value   (diff),
    .clamped (sat_out)
  );

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      acc        <= '0;
      bus.o_data <= '0;
    end else if (bus.enable_3M) begin
`ifdef DC_FILTER_BYPASS_EN
      if (bus.bypass) begin
        acc        <= ACC_W'(bus.c_data) <<< SHIFT;
        bus.o_data <= bus.c_data;
      end else begin
        acc        <= acc + ACC_W'(bus.c_data) - ACC_W'(est);
        bus.o_data <= sat_out;
      end
`else
      acc        <= acc + ACC_W'(bus.c_data) - ACC_W'(est);
      bus.o_data <= sat_out;
`endif
    end
  end

endmodule

// File: tb/tb_dc_block_iir.sv
// Scoreboard bench for dc_block_iir: reset, DC step decay, strobe gating, saturation, tone pass-band.
// Exercises the bypass path as well when DC_FILTER_BYPASS_EN is defined.
module tb_dc_block_iir;
  import dc_block_pkg::*;

  localparam int K = 10;

  logic clk = 1'b0;
  logic reset;
  always #20 clk = ~clk;

  dc_block_iir_if bif ();

  dc_block_iir dut (
    .CLK_24M (clk),
    .reset   (reset),
    .bus     (bif)
  );

  int     checks   = 0;
  int     failures = 0;
  int     exp_q[$];
  longint m_acc    = 0;
  int     last_out = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp9(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic int model_step(input int x, input bit byp);
    longint est;
    if (byp) begin
      m_acc = longint'(x) * 1024;
      return x;
    end
    est   = m_acc >>> K;
    m_acc = m_acc + x - est;
    return clamp9(x - int'(est));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Called with the bench positioned 1 time unit after a rising edge.
  task automatic strobe(input int x, input int gap, input string tag, input bit byp = 1'b0);
    bif.enable_3M = 1'b1;
    bif.c_data    = DC_DATA_W'(x);
    exp_q.push_back(model_step(x, byp));
    @(posedge clk); #1;
    bif.enable_3M = 1'b0;
    last_out = int'(bif.o_data);
    if (exp_q.size() == 0) check({tag, "_empty_q"}, 1, 0);
    else                   check(tag, last_out, exp_q.pop_front());
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bif.enable_3M = 1'b1;
    bif.c_data    = 9'sd100;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_out", int'(bif.o_data), 0);
    end
    reset         = 1'b0;
    bif.enable_3M = 1'b0;
    m_acc         = 0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  prev;
    int  x;
    longint sum;
    int  peak;
    real ph;

    reset         = 1'b1;
    bif.enable_3M = 1'b0;
    bif.c_data    = '0;
`ifdef DC_FILTER_BYPASS_EN
    bif.bypass    = 1'b0;
`endif
    #1;

    // Reset and DC step from power-up.
    do_reset();
    strobe(100, 8, "dc_s1");
    check("first_after_reset", last_out, 100);
    strobe(100, 8, "dc_s2");
    check("dc_second", last_out, 100);
    prev = last_out;
    for (int i = 2; i < 8192; i++) begin
      strobe(100, (i < 200) ? int'($urandom_range(2, 8)) : 2, "dc_step");
      check("dc_mono", int'(last_out <= prev), 1);
      prev = last_out;
    end
    check("dc_settle", int'(iabs(last_out) <= 1), 1);

    // Input changes between strobes must not reach the output or the integrator.
    strobe(-120, 1, "gate_first");
    prev = last_out;
    for (int i = 0; i < 6; i++) begin
      bif.c_data = DC_DATA_W'($urandom_range(0, 511));
      @(posedge clk); #1;
      check("gate_hold", int'(bif.o_data), prev);
    end
    strobe(-37, 2, "gate_next");
    strobe(-37, 2, "gate_next2");

    // Mid-operation reset, then saturation in both directions.
    do_reset();
    for (int i = 0; i < 3000; i++) strobe(-256, 2, "sat_settle_lo");
    strobe(255, 2, "sat_step_hi");
    check("sat_hi", last_out, 255);
    for (int i = 0; i < 3000; i++) strobe(255, 2, "sat_settle_hi");
    strobe(-256, 2, "sat_step_lo");
    check("sat_lo", last_out, -256);

    // Tone: 300 samples per period at the 3 MHz rate, offset +50.
    do_reset();
    sum  = 0;
    peak = 0;
    for (int n = 0; n < 9000; n++) begin
      ph = 2.0 * 3.14159265358979 * real'(n % 300) / 300.0;
      x  = 50 + int'(128.0 * $sin(ph));
      strobe(x, 2, "tone");
      if (n >= 6000) begin
        sum += last_out;
        if (last_out > peak) peak = last_out;
      end
    end
    check("tone_mean", int'(iabs(int'(sum / 3000)) <= 2), 1);
    check("tone_peak", int'(peak >= 120), 1);

`ifdef DC_FILTER_BYPASS_EN
    bif.bypass = 1'b1;
    strobe(77, 2, "byp_on", 1'b1);
    check("byp_pass", last_out, 77);
    bif.bypass = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(77, 2, "byp_exit");
      check("byp_exit_small", int'(iabs(last_out) <= 1), 1);
    end
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_block_iir.md
Name: dc_block_iir

Overview:
- First-order DC-removal (high-pass) filter for the 9-bit signed sample stream running at the 3 MHz decimated rate.
- Runs on the 24 MHz system clock.
- Processes one sample per `enable_3M` strobe.
- Tracks the DC level with a leaky integrator and subtracts it from each input sample.

Parameters:
- DATA_W, 9: width of the signed input/output samples.
- SHIFT, 10: integrator leak shift K. Corner ≈ fs/(2π·2^K), about 466 Hz at fs = 3 MHz.
- ACC_W, DATA_W+SHIFT+1: signed DC-accumulator width, including one guard bit.

Ports:
- CLK_24M  in  1  system clock, 24 MHz; all logic on its rising edge
- reset  in  1  synchronous, active-high; clears all state
- enable_3M  in  1  sample strobe, one CLK_24M cycle wide, nominally every 8 clocks; spacing is arbitrary but at least 2 clocks
- c_data  in  DATA_W  signed two's-complement input sample; valid in the strobe cycle
- o_data  out  DATA_W  signed two's-complement filtered sample, registered

Behaviour:
- Reset (sampled on CLK_24M rising edge while reset=1): acc <= 0, o_data <= 0. Reset has priority over enable_3M.
- Mid-operation reset discards the DC estimate. The first sample after reset behaves like power-up.
- DC estimate: est = acc >>> SHIFT (arithmetic shift, floor rounding), DATA_W+1 bits signed.
- On an edge with enable_3M=1 and reset=0, both updates use the pre-edge acc:
  - acc <= acc + sext(c_data) − sext(est)
  - o_data <= sat(sext(c_data) − est)
- sat() clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−256, 255].
- acc never overflows: |acc| ≤ 2^(DATA_W−1+SHIFT) by construction. No wrap-around is permitted.
- Latency: o_data reflects the strobed sample from the clock edge that samples the strobe, i.e. one clock after the strobe cycle begins. It holds stable until the next strobe.
- enable_3M=0: acc and o_data hold.
- Steady state:
  - Constant input X: o_data decays geometrically (ratio 1−2^−SHIFT per sample) to within ±1 of 0.
  - Tones well above the corner pass with gain ≈1.
- No handshake and no back-pressure. Purely a strobe-qualified pipeline with no FSM.

Optional Feature:
- Macro DC_FILTER_BYPASS_EN.
- When defined: adds input port `bypass` (1 bit).
  - On a strobe with bypass=1: o_data <= c_data and acc <= sext(c_data) << SHIFT, so the estimate is pre-loaded and there is no transient on exit.
  - With bypass=0 the filter behaves normally.
- When undefined: no `bypass` port, behaviour exactly as above, no extra logic.

Decomposition:
- Package dc_block_pkg holds:
  - default DATA_W and SHIFT localparams
  - a sample typedef (logic signed [DATA_W-1:0])
  - the sat() function (saturate a DATA_W+1 signed value to DATA_W)
- One natural sub-module: dc_block_sat, a combinational saturator used on the output path.
- The top instantiates it once and owns the acc and o_data registers.

Test Plan:
- Reset: hold reset=1 for 3 clocks with strobes and c_data=100 → o_data=0 throughout. First strobe after release with c_data=100 → o_data=100.
- DC step: c_data constant 100 from reset, strobe every 8 clocks.
  - Sample 1 → 100; sample 2 → 100; o_data decreases monotonically.
  - After 8·2^SHIFT (8192) strobes → |o_data| ≤ 1.
- Strobe gating: c_data changes between strobes → o_data and internal acc unchanged until the next enable_3M=1 cycle.
- Saturation: settle on c_data=−256 (o_data≈0), then step to 255 → o_data=255, not wrapped. Step back to −256 → o_data=−256.
- Tone: 10 kHz sine, amplitude 128, offset +50, 3 MHz strobes, 100000 clocks → after settling, output mean within ±2 of 0 and peak ≥ 120.
- Bypass (DC_FILTER_BYPASS_EN): bypass=1, c_data=77 → o_data=77. Deassert bypass with c_data held at 77 → next outputs within ±1 of 0.
